// File: rtl/cpu_pkg.sv
// Shared types for the 2-stage MIPS core: fetch FSM states, PC source select, NOP encoding.
package cpu_pkg;

    typedef enum logic [1:0] {FILL, RUN, STALL, HALT} fetch_state_t;

    typedef enum logic [1:0] {PC_SEQ, PC_BR, PC_J, PC_JR} pc_src_t;

    localparam logic [31:0] NOP_INSTR = 32'b0;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, conditional branch, jump, jump-register.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = 12
) (
    input  logic [PC_W-1:0] pc,
    input  pc_src_t         pc_src,
    input  logic            branch_ne,
    input  logic            zero,
    input  logic [15:0]     imm,
    input  logic [25:0]     jtarget,
    input  logic [31:0]     rs,
    output logic [PC_W-1:0] next_pc
);

    logic [31:0]     imm_sext;
    logic [PC_W-1:0] pc_inc;
    logic            taken;

    assign imm_sext = {{16{imm[15]}}, imm};
    assign pc_inc   = pc + PC_W'(1);
    assign taken    = zero ^ branch_ne;

    // pc already points at the delay slot, so the offset is applied to branch PC + 1
    always_comb begin
        next_pc = pc_inc;
        unique case (pc_src)
            PC_SEQ: next_pc = pc_inc;
            PC_BR:  next_pc = taken ? (pc + imm_sext[PC_W-1:0]) : pc_inc;
            PC_J:   next_pc = jtarget[PC_W-1:0];
            PC_JR:  next_pc = rs[PC_W+1:2];
            default: next_pc = pc_inc;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the fetch PC, the instruction_EX load/hold/clear sequencing, halt/stall handling
// and the saturating retired-instruction counter.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W     = 12,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       pc_src_EX,
    input  logic             branch_ne_EX,
    input  logic             zero_EX,
    input  logic [15:0]      imm_EX,
    input  logic [25:0]      jtarget_EX,
    input  logic [31:0]      rs_EX,
    input  logic             halt_EX,
    input  logic             stall_req,
    output logic [PC_W-1:0]  pc_FETCH,
    output logic             instr_load_en,
    output logic             instr_clear,
    output logic             valid_EX,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             valid_q, valid_d;
    logic [PC_W-1:0]  next_pc;
    logic             advance;
    logic             count;

    next_pc_calc #(
        .PC_W (PC_W)
    ) u_next_pc_calc (
        .pc        (pc_q),
        .pc_src    (pc_src_t'(pc_src_EX)),
        .branch_ne (branch_ne_EX),
        .zero      (zero_EX),
        .imm       (imm_EX),
        .jtarget   (jtarget_EX),
        .rs        (rs_EX),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            pc_q      <= PC_W'(RESET_PC);
            retired_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:  state_d = RUN;
            RUN:   begin
                if (halt_EX)        state_d = HALT;
                else if (stall_req) state_d = STALL;
            end
            STALL: if (!stall_req) state_d = RUN;
            HALT:  state_d = HALT;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        advance       = 1'b0;
        count         = 1'b0;
        instr_load_en = 1'b0;
        instr_clear   = 1'b0;
        valid_d       = valid_q;
        unique case (state_q)
            FILL: begin
                advance = 1'b1;
                valid_d = 1'b0;
            end
            RUN, STALL: begin
                if (state_q == RUN && halt_EX) begin
                    // halt wins over a simultaneous stall and still retires
                    instr_clear = 1'b1;
                    count       = 1'b1;
                    valid_d     = 1'b0;
                end else if (!stall_req && !halt_EX) begin
                    advance = 1'b1;
                    count   = 1'b1;
                    valid_d = 1'b1;
                end
            end
            HALT: valid_d = 1'b0;
            default: valid_d = 1'b0;
        endcase
        instr_load_en = advance;
        pc_d          = advance ? next_pc : pc_q;
        retired_d     = (count && retired_q != '1) ? retired_q + CNT_W'(1) : retired_q;
    end

    assign pc_FETCH = pc_q;
    assign valid_EX = valid_q;
    assign halted   = (state_q == HALT);
    assign retired  = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (counter narrowed to 4 bits for saturation).
module tb_fetch_sequencer;
    import cpu_pkg::*;

    localparam int unsigned PC_W  = 12;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       pc_src_EX;
    logic             branch_ne_EX;
    logic             zero_EX;
    logic [15:0]      imm_EX;
    logic [25:0]      jtarget_EX;
    logic [31:0]      rs_EX;
    logic             halt_EX;
    logic             stall_req;
    logic [PC_W-1:0]  pc_FETCH;
    logic             instr_load_en;
    logic             instr_clear;
    logic             valid_EX;
    logic             halted;
    logic [CNT_W-1:0] retired;

    int errors = 0;
    int checks = 0;

    fetch_sequencer #(
        .PC_W     (PC_W),
        .RESET_PC (0),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_src_EX     (pc_src_EX),
        .branch_ne_EX  (branch_ne_EX),
        .zero_EX       (zero_EX),
        .imm_EX        (imm_EX),
        .jtarget_EX    (jtarget_EX),
        .rs_EX         (rs_EX),
        .halt_EX       (halt_EX),
        .stall_req     (stall_req),
        .pc_FETCH      (pc_FETCH),
        .instr_load_en (instr_load_en),
        .instr_clear   (instr_clear),
        .valid_EX      (valid_EX),
        .halted        (halted),
        .retired       (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_src_EX    = PC_SEQ;
        branch_ne_EX = 1'b0;
        zero_EX      = 1'b0;
        imm_EX       = 16'h0;
        jtarget_EX   = 26'h0;
        rs_EX        = 32'h0;
        halt_EX      = 1'b0;
        stall_req    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // 1. reset state and sequential fill
        do_reset();
        check("rst_pc", 32'(pc_FETCH), 32'h0);
        check("rst_valid", 32'(valid_EX), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_retired", 32'(retired), 32'h0);
        check("rst_load_en", 32'(instr_load_en), 32'h1);
        check("rst_clear", 32'(instr_clear), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(FILL));
        step();
        check("seq_pc1", 32'(pc_FETCH), 32'h1);
        check("seq_valid1", 32'(valid_EX), 32'h0);
        check("seq_ret1", 32'(retired), 32'h0);
        for (int i = 2; i <= 5; i++) begin
            step();
            check("seq_pc", 32'(pc_FETCH), 32'(i));
            check("seq_valid", 32'(valid_EX), 32'h1);
        end
        check("seq_ret5", 32'(retired), 32'h4);

        // 2. branches: beq taken, beq not taken, bne taken
        pc_src_EX = PC_J; jtarget_EX = 26'h10;
        step();
        check("j_to_010", 32'(pc_FETCH), 32'h010);
        pc_src_EX = PC_BR; imm_EX = 16'hFFFC; zero_EX = 1'b1; branch_ne_EX = 1'b0;
        step();
        check("beq_taken", 32'(pc_FETCH), 32'h00C);
        pc_src_EX = PC_J; jtarget_EX = 26'h10;
        step();
        pc_src_EX = PC_BR; zero_EX = 1'b0;
        step();
        check("beq_not_taken", 32'(pc_FETCH), 32'h011);
        branch_ne_EX = 1'b1;
        step();
        check("bne_taken", 32'(pc_FETCH), 32'h00D);
        check("br_ret", 32'(retired), 32'h9);

        // 3. jump, jr and wrap
        do_reset();
        step();
        pc_src_EX = PC_J; jtarget_EX = 26'h0000ABC;
        step();
        check("j_abc", 32'(pc_FETCH), 32'hABC);
        pc_src_EX = PC_JR; rs_EX = 32'h0000_0104;
        step();
        check("jr_041", 32'(pc_FETCH), 32'h041);
        rs_EX = 32'hFFFF_3FFF;
        step();
        check("jr_fff", 32'(pc_FETCH), 32'hFFF);
        pc_src_EX = PC_SEQ;
        step();
        check("seq_wrap", 32'(pc_FETCH), 32'h000);
        pc_src_EX = PC_J; jtarget_EX = 26'h3FFF123;
        step();
        check("j_trunc", 32'(pc_FETCH), 32'h123);

        // 4. stall with pending jump
        do_reset();
        step();
        step();
        check("pre_stall_pc", 32'(pc_FETCH), 32'h2);
        check("pre_stall_ret", 32'(retired), 32'h1);
        stall_req = 1'b1; pc_src_EX = PC_J; jtarget_EX = 26'h20;
        #1;
        check("stall_load_en", 32'(instr_load_en), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", 32'(pc_FETCH), 32'h2);
            check("stall_ret", 32'(retired), 32'h1);
            check("stall_state", 32'(dut.state_q), 32'(STALL));
            check("stall_valid", 32'(valid_EX), 32'h1);
            check("stall_hold", 32'(instr_load_en), 32'h0);
        end
        stall_req = 1'b0;
        #1;
        check("release_load_en", 32'(instr_load_en), 32'h1);
        step();
        check("release_pc", 32'(pc_FETCH), 32'h020);
        check("release_ret", 32'(retired), 32'h2);
        check("release_state", 32'(dut.state_q), 32'(RUN));

        // 5. halt beats stall
        pc_src_EX = PC_SEQ; halt_EX = 1'b1; stall_req = 1'b1;
        #1;
        check("halt_clear", 32'(instr_clear), 32'h1);
        check("halt_no_load", 32'(instr_load_en), 32'h0);
        step();
        check("halted", 32'(halted), 32'h1);
        check("halt_valid", 32'(valid_EX), 32'h0);
        check("halt_ret", 32'(retired), 32'h3);
        check("halt_clear_off", 32'(instr_clear), 32'h0);
        halt_EX = 1'b0; stall_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("halt_pc_frozen", 32'(pc_FETCH), 32'h020);
        check("halt_ret_frozen", 32'(retired), 32'h3);
        check("halt_load_off", 32'(instr_load_en), 32'h0);
        check("halt_stays", 32'(halted), 32'h1);

        // 6. async reset mid-stall, then counter saturation
        do_reset();
        step();
        pc_src_EX = PC_J; jtarget_EX = 26'h55;
        step();
        stall_req = 1'b1;
        step();
        check("pre_rst_pc", 32'(pc_FETCH), 32'h055);
        check("pre_rst_state", 32'(dut.state_q), 32'(STALL));
        rst = 1'b1;
        #1;
        check("async_pc", 32'(pc_FETCH), 32'h0);
        check("async_state", 32'(dut.state_q), 32'(FILL));
        check("async_ret", 32'(retired), 32'h0);
        rst = 1'b0;
        idle_inputs();
        step();
        for (int i = 0; i < 15; i++) step();
        check("sat_reach", 32'(retired), 32'hF);
        for (int i = 0; i < 3; i++) step();
        check("sat_hold", 32'(retired), 32'hF);
        check("sat_pc", 32'(pc_FETCH), 32'd19);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
